bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter; next generation of the team's fixed 4-digit 0–9999 loadable counter.
- Adds:
  - a generic digit count
  - a count enable
  - direction control
  - wrap or saturate mode
  - a terminal-count pulse
  - load validation
- Instantiated inside user_project_wrapper, driven by wb_clk_i and logic-analyzer bits; digits exported on la_data_out / io_out.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width W = 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  mode: 1 = saturate at boundary, 0 = wrap.
- load  input  1  synchronous load request.
- load_value  input  W  packed BCD load value; digit 0 (units) in [3:0].
- count  output  W  packed BCD count; digit k in [4k+3:4k].
- tc  output  1  registered terminal-count pulse.
- load_err  output  1  registered pulse: load rejected, non-BCD nibble.

Behaviour:
- Reset (asynchronous, active-high): count = 0, tc = 0, load_err = 0. All outputs are registered; no combinational path from inputs to outputs.
- Priority per rising edge: load > en step > hold.
- Load:
  - If every nibble of load_value is ≤ 9: count <= load_value next edge; tc = 0 that cycle; load_err = 0.
  - If any nibble is > 9: count unchanged, load_err = 1 for exactly one cycle.
  - A step requested in the same cycle as a load (valid or rejected) is discarded.
- Up step (en=1, up=1):
  - Digit 0 increments.
  - Digit k (k > 0) increments only when all lower digits are 9.
  - A digit at 9 that increments becomes 0 and carries.
- Down step (en=1, up=0):
  - Digit 0 decrements.
  - Digit k (k > 0) decrements only when all lower digits are 0.
  - A digit at 0 that decrements becomes 9 and borrows.
- Boundaries: MAX = all digits 9, MIN = all 0.
  - Wrap mode (sat=0): up at MAX -> MIN; down at MIN -> MAX. tc = 1 for the one cycle after the wrapping edge.
  - Saturate mode (sat=1): up at MAX, or down at MIN -> count holds. tc = 1 for the cycle after the edge on which count reaches the boundary via a step (e.g. 9998 -> 9999). tc stays 0 on subsequent held cycles.
  - Load onto a boundary never raises tc.
- Direction or mode may change on any cycle; the new value applies at the next edge with no pipeline effect.
- en=0 with no load: count holds, tc = 0, load_err = 0.
- Latency: one cycle from input sample to updated count / tc / load_err.
- Reset asserted mid-count: immediate clear regardless of clk. Counting resumes on the first edge after deassertion when en=1.
- Count never holds a non-BCD nibble in any reachable state.

Test Plan:
1. Reset with DIGITS=4: assert reset asynchronously mid-cycle with count=0x4321 -> count=0x0000 immediately; tc=0, load_err=0.
2. Load then count up, wrap mode: load 0x9997, en=1, up=1, sat=0 -> count 9998, 9999, 0000, 0001. tc=1 only in the cycle showing 0000.
3. Decimal carry/borrow chain: load 0x0999, step up once -> 0x1000. Then step down once -> 0x0999, tc=0 throughout.
4. Saturate down: load 0x0002, en=1, up=0, sat=1 -> 0001, 0000, 0000, 0000. tc=1 only in the first cycle showing 0000.
5. Invalid load: count=0x0123, load=1 with load_value=0x12A4 and en=1 -> count stays 0x0123, load_err=1 for one cycle, no step taken. Next cycle (load=0, en=1) -> 0x0124.
6. Load/en collision at boundary: count=0x9999, sat=0, en=1, up=1, load=1 with load_value=0x5000 -> count=0x5000, tc=0.

Source files
------------

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with synchronous load, wrap/saturate modes,
// a registered terminal-count pulse and rejection of non-BCD load values.
// Digit k lives in count[4k+3:4k]; digit 0 is the units digit.
module bcd_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] step_value;   // count after one step in the current direction
  logic         chain_out;    // carry/borrow out of the top digit: count was at MAX (up) or MIN (down)
  logic         load_ok;      // every nibble of load_value is a legal BCD digit
  logic [W-1:0] boundary;     // MAX when counting up, MIN when counting down
  logic         reach;        // the step lands exactly on the boundary

  // Ripple the carry (up) or borrow (down) from the units digit upward.
  always_comb begin
    logic       chain;
    logic [3:0] dig;
    step_value = count;
    chain      = 1'b1;
    dig        = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count[4*k +: 4];
      if (chain) begin
        if (up) begin
          if (dig == 4'd9) begin
            step_value[4*k +: 4] = 4'd0;
          end else begin
            step_value[4*k +: 4] = dig + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_value[4*k +: 4] = 4'd9;
          end else begin
            step_value[4*k +: 4] = dig - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
    chain_out = chain;
  end

  // A load is accepted only if no nibble exceeds 9.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_value[4*k +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Boundary in the current direction and whether a step reaches it.
  always_comb begin
    boundary = up ? {DIGITS{4'h9}} : {W{1'b0}};
    reach    = (step_value == boundary);
  end

  // Count register with load > step > hold priority; tc and load_err are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // Any step requested alongside a load is dropped, accepted or not.
        if (load_ok) begin
          count <= load_value;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (chain_out) begin
          // Already at the boundary: wrap and flag it, or sit still silently.
          if (!sat) begin
            count <= step_value;
            tc    <= 1'b1;
          end
        end else begin
          count <= step_value;
          // In saturate mode the pulse marks arriving at the boundary.
          tc    <= sat && reach;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n with DIGITS=4 and hand-computed expectations.
module tb_bcd_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic         sat;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tc;
  logic         load_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .sat        (sat),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .load_err   (load_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic l, input logic [W-1:0] lv, input logic e,
                       input logic u, input logic s);
    load       = l;
    load_value = lv;
    en         = e;
    up         = u;
    sat        = s;
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [W-1:0] c,
                              input logic t, input logic le);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_state("por", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // 1. Asynchronous reset mid-cycle while counting
    drive(1'b1, 16'h4321, 1'b0, 1'b1, 1'b0);
    tick();
    expect_state("t1_load", 16'h4321, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    expect_state("t1_async", 16'h0000, 1'b0, 1'b0);
    tick();
    expect_state("t1_held", 16'h0000, 1'b0, 1'b0);
    #2 reset = 1'b0;
    tick();
    expect_state("t1_resume", 16'h0001, 1'b0, 1'b0);

    // 2. Load then count up through a wrap
    drive(1'b1, 16'h9997, 1'b1, 1'b1, 1'b0);
    tick();
    expect_state("t2_load", 16'h9997, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("t2_9998", 16'h9998, 1'b0, 1'b0);
    tick(); expect_state("t2_9999", 16'h9999, 1'b0, 1'b0);
    tick(); expect_state("t2_0000", 16'h0000, 1'b1, 1'b0);
    tick(); expect_state("t2_0001", 16'h0001, 1'b0, 1'b0);

    // 3. Decimal carry and borrow chains
    drive(1'b1, 16'h0999, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("t3_load", 16'h0999, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("t3_carry", 16'h1000, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(); expect_state("t3_borrow", 16'h0999, 1'b0, 1'b0);

    // 4. Saturating down count
    drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
    tick(); expect_state("t4_load", 16'h0002, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick(); expect_state("t4_0001", 16'h0001, 1'b0, 1'b0);
    tick(); expect_state("t4_reach", 16'h0000, 1'b1, 1'b0);
    tick(); expect_state("t4_hold1", 16'h0000, 1'b0, 1'b0);
    tick(); expect_state("t4_hold2", 16'h0000, 1'b0, 1'b0);

    // Wrap mode down from MIN goes to MAX with tc
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(); expect_state("dn_wrap", 16'h9999, 1'b1, 1'b0);

    // Saturating up to MAX, then held
    drive(1'b1, 16'h9998, 1'b0, 1'b1, 1'b1);
    tick(); expect_state("su_load", 16'h9998, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
    tick(); expect_state("su_reach", 16'h9999, 1'b1, 1'b0);
    tick(); expect_state("su_hold", 16'h9999, 1'b0, 1'b0);

    // 5. Invalid load rejected, step discarded
    drive(1'b1, 16'h0123, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("t5_load", 16'h0123, 1'b0, 1'b0);
    drive(1'b1, 16'h12A4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("t5_reject", 16'h0123, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("t5_step", 16'h0124, 1'b0, 1'b0);
    drive(1'b1, 16'hF000, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("t5_top_nib", 16'h0124, 1'b0, 1'b1);

    // 6. Load onto boundary, then load/en collision at MAX
    drive(1'b1, 16'h9999, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("t6_load_max", 16'h9999, 1'b0, 1'b0);
    drive(1'b1, 16'h5000, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("t6_collide", 16'h5000, 1'b0, 1'b0);

    // en=0 holds
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("hold", 16'h5000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
